// File: rtl/voq_sched_rr_pkg.sv
// Shared types and wrap helper for the VOQ round-robin scheduler.
// Optional feature macro used by the scheduler: SCHED_EGRESS_RR_EN.
package voq_sched_pkg;

  localparam int N_PORTS_MAX = 16;

  typedef enum logic [1:0] {
    IDLE,
    ASSIGN,
    ISSUE
  } sched_state_t;

  function automatic int inc_mod(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/voq_sched_rr_if.sv
// Scheduler-side bundle between the ingress VOQ blocks and the crossbar scheduler.
// master drives requests and queue status; slave is the scheduler.
interface voq_sched_rr_if #(
  parameter int N_PORTS = 4
);
  localparam int PORT_W = $clog2(N_PORTS);

  logic                         sched_en;
  logic [N_PORTS-1:0]           is_busy;
  logic [N_PORTS*PORT_W-1:0]    busy_voq_num;
  logic [N_PORTS*N_PORTS-1:0]   voq_empty;
  logic [N_PORTS-1:0]           sched_sel_en;
  logic [N_PORTS*PORT_W-1:0]    sched_sel;
  logic                         sched_done;
  logic                         sched_active;

  modport master (
    output sched_en, is_busy, busy_voq_num, voq_empty,
    input  sched_sel_en, sched_sel, sched_done, sched_active
  );

  modport slave (
    input  sched_en, is_busy, busy_voq_num, voq_empty,
    output sched_sel_en, sched_sel, sched_done, sched_active
  );
endinterface

// File: rtl/voq_sched_rr_pick.sv
// Combinational round-robin VOQ pick: first non-empty, not-yet-picked egress
// at or after start, wrapping modulo N_PORTS.
module voq_pick_rr
  import voq_sched_pkg::*;
#(
  parameter int N_PORTS = 4,
  localparam int PORT_W = $clog2(N_PORTS)
) (
  input  logic [PORT_W-1:0]  start,
  input  logic [N_PORTS-1:0] empty,
  input  logic [N_PORTS-1:0] picked,
  output logic               none_avail,
  output logic [PORT_W-1:0]  pick
);

  logic [PORT_W-1:0] idx;

  always_comb begin
    none_avail = 1'b1;
    pick       = '0;
    idx        = start;
    for (int k = 0; k < N_PORTS; k++) begin
      if (none_avail && !empty[idx] && !picked[idx]) begin
        none_avail = 1'b0;
        pick       = idx;
      end
      idx = PORT_W'(inc_mod(int'(idx), N_PORTS));
    end
  end

endmodule

// File: rtl/voq_sched_rr.sv
// N-port VOQ crossbar scheduler: one ingress assigned per cycle, round-robin over
// ingresses and per-ingress VOQs. SCHED_EGRESS_RR_EN selects the VOQ pointer update.
//
//  state  | meaning
//  IDLE   | waiting for sched_en; snapshot inputs on accept
//  ASSIGN | one ingress per cycle, N_PORTS cycles starting at the start pointer
//  ISSUE  | pulse sched_sel_en/sched_done, advance start pointer
module voq_sched_rr
  import voq_sched_pkg::*;
#(
  parameter int N_PORTS = 4
) (
  input logic           clk,
  input logic           reset,
  voq_sched_rr_if.slave bus
);

  localparam int PORT_W = $clog2(N_PORTS);
  localparam logic [PORT_W-1:0] LAST = PORT_W'(N_PORTS - 1);

  if (N_PORTS < 2 || N_PORTS > N_PORTS_MAX) begin : g_bad_cfg
    $error("voq_sched_rr: N_PORTS out of range");
  end

  sched_state_t state, state_nxt;

  logic [PORT_W-1:0]  cur, cnt, start_ptr;
  logic [PORT_W-1:0]  voq_ptr     [N_PORTS];
  logic [PORT_W-1:0]  work_sel    [N_PORTS];
  logic [PORT_W-1:0]  out_sel     [N_PORTS];
  logic [PORT_W-1:0]  sh_busy_voq [N_PORTS];
  logic [N_PORTS-1:0] sh_empty    [N_PORTS];
  logic [N_PORTS-1:0] sh_busy, picked, acc, busy_mask;

  logic               none_avail, cur_en, ptr_upd, done;
  logic [PORT_W-1:0]  pick, cur_sel, ptr_nxt;
  logic [N_PORTS-1:0] sel_en;

  voq_pick_rr #(.N_PORTS(N_PORTS)) u_pick (
    .start      (voq_ptr[cur]),
    .empty      (sh_empty[cur]),
    .picked     (picked),
    .none_avail (none_avail),
    .pick       (pick)
  );

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (bus.is_busy[i]) busy_mask[bus.busy_voq_num[i*PORT_W +: PORT_W]] = 1'b1;
    end
  end

  // busy ingresses keep their egress and never move their VOQ pointer
  always_comb begin
    cur_en  = 1'b0;
    cur_sel = work_sel[cur];
    ptr_upd = 1'b0;
    if (sh_busy[cur]) begin
      cur_en  = 1'b1;
      cur_sel = sh_busy_voq[cur];
    end else if (!none_avail) begin
      cur_en  = 1'b1;
      cur_sel = pick;
      ptr_upd = 1'b1;
    end
  end

`ifdef SCHED_EGRESS_RR_EN
  assign ptr_nxt = PORT_W'(inc_mod(int'(pick), N_PORTS));
`else
  assign ptr_nxt = PORT_W'(inc_mod(int'(voq_ptr[cur]), N_PORTS));
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    sel_en    = '0;
    case (state)
      IDLE:    if (bus.sched_en) state_nxt = ASSIGN;
      ASSIGN:  if (cnt == LAST) state_nxt = ISSUE;
      ISSUE: begin
        state_nxt = IDLE;
        done      = 1'b1;
        sel_en    = acc;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur       <= '0;
      cnt       <= '0;
      start_ptr <= '0;
      sh_busy   <= '0;
      picked    <= '0;
      acc       <= '0;
      for (int i = 0; i < N_PORTS; i++) begin
        voq_ptr[i]     <= '0;
        work_sel[i]    <= '0;
        out_sel[i]     <= '0;
        sh_busy_voq[i] <= '0;
        sh_empty[i]    <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.sched_en) begin
            sh_busy <= bus.is_busy;
            picked  <= busy_mask;
            acc     <= '0;
            cur     <= start_ptr;
            cnt     <= '0;
            for (int i = 0; i < N_PORTS; i++) begin
              sh_busy_voq[i] <= bus.busy_voq_num[i*PORT_W +: PORT_W];
              sh_empty[i]    <= bus.voq_empty[i*N_PORTS +: N_PORTS];
            end
          end
        end
        ASSIGN: begin
          cur <= PORT_W'(inc_mod(int'(cur), N_PORTS));
          cnt <= cnt + 1'b1;
          if (cur_en) begin
            acc[cur]        <= 1'b1;
            work_sel[cur]   <= cur_sel;
            picked[cur_sel] <= 1'b1;
          end
          if (ptr_upd) voq_ptr[cur] <= ptr_nxt;
          // publish the whole selection at once so sched_sel is stable between issues
          if (cnt == LAST) begin
            for (int i = 0; i < N_PORTS; i++) begin
              out_sel[i] <= (cur_en && cur == PORT_W'(i)) ? cur_sel : work_sel[i];
            end
          end
        end
        ISSUE: start_ptr <= PORT_W'(inc_mod(int'(start_ptr), N_PORTS));
        default: ;
      endcase
    end
  end

  assign bus.sched_done   = done;
  assign bus.sched_sel_en = sel_en;
  assign bus.sched_active = (state != IDLE);

  for (genvar g = 0; g < N_PORTS; g++) begin : g_sel
    assign bus.sched_sel[g*PORT_W +: PORT_W] = out_sel[g];
  end

endmodule

// File: tb/tb_voq_sched_rr.sv
// Scoreboard bench for voq_sched_rr at N_PORTS=4 and N_PORTS=5; expectations are
// hand-computed and honour SCHED_EGRESS_RR_EN when defined.
module tb_voq_sched_rr;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  voq_sched_rr_if #(.N_PORTS(4)) bus4 ();
  voq_sched_rr_if #(.N_PORTS(5)) bus5 ();

  voq_sched_rr #(.N_PORTS(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  voq_sched_rr #(.N_PORTS(5)) dut5 (.clk(clk), .reset(reset), .bus(bus5));

  typedef struct {
    int          at;
    logic [4:0]  en;
    logic [14:0] sel;
    string       name;
  } exp_t;

  exp_t q4[$];
  exp_t q5[$];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int slice(input logic [14:0] s, input int i, input int pw);
    logic [14:0] v;
    v = (s >> (i * pw)) & ((15'd1 << pw) - 15'd1);
    return int'(v);
  endfunction

  function automatic logic [14:0] s4(input int a0, input int a1, input int a2, input int a3);
    return 15'({2'(a3), 2'(a2), 2'(a1), 2'(a0)});
  endfunction

  function automatic logic [14:0] s5(input int a0, input int a1, input int a2, input int a3,
                                     input int a4);
    return {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  task automatic score(input int n, input int pw, input exp_t e, input logic [4:0] en,
                       input logic [14:0] sel);
    int dup;
    check({e.name, " time"}, cyc, e.at);
    check({e.name, " en"}, int'(en), int'(e.en));
    for (int i = 0; i < n; i++) begin
      if (e.en[i]) check($sformatf("%s sel[%0d]", e.name, i), slice(sel, i, pw), slice(e.sel, i, pw));
    end
    dup = 0;
    for (int i = 0; i < n; i++) begin
      for (int j = i + 1; j < n; j++) begin
        if (en[i] && en[j] && slice(sel, i, pw) == slice(sel, j, pw)) dup++;
      end
    end
    check({e.name, " distinct"}, dup, 0);
  endtask

  // monitors: pop one expectation per done pulse
  always @(negedge clk) begin
    if (bus4.sched_done === 1'b1) begin
      if (q4.size() == 0) check("dut4 unexpected done", 1, 0);
      else score(4, 2, q4.pop_front(), 5'(bus4.sched_sel_en), 15'(bus4.sched_sel));
    end else if (bus4.sched_sel_en !== 4'b0) begin
      check("dut4 sel_en outside done", int'(bus4.sched_sel_en), 0);
    end
  end

  always @(negedge clk) begin
    if (bus5.sched_done === 1'b1) begin
      if (q5.size() == 0) check("dut5 unexpected done", 1, 0);
      else score(5, 3, q5.pop_front(), bus5.sched_sel_en, bus5.sched_sel);
    end else if (bus5.sched_sel_en !== 5'b0) begin
      check("dut5 sel_en outside done", int'(bus5.sched_sel_en), 0);
    end
  end

  task automatic issue4(input string name, input logic [3:0] busy, input logic [7:0] bvoq,
                        input logic [15:0] empty, input bit expect_done,
                        input logic [3:0] en, input logic [14:0] sel);
    exp_t e;
    @(negedge clk);
    bus4.is_busy      = busy;
    bus4.busy_voq_num = bvoq;
    bus4.voq_empty    = empty;
    bus4.sched_en     = 1'b1;
    if (expect_done) begin
      e.at = cyc + 5; e.en = 5'(en); e.sel = sel; e.name = name;
      q4.push_back(e);
    end
    @(negedge clk);
    bus4.sched_en = 1'b0;
  endtask

  task automatic issue5(input string name, input logic [24:0] empty,
                        input logic [4:0] en, input logic [14:0] sel);
    exp_t e;
    @(negedge clk);
    bus5.is_busy      = '0;
    bus5.busy_voq_num = '0;
    bus5.voq_empty    = empty;
    bus5.sched_en     = 1'b1;
    e.at = cyc + 6; e.en = en; e.sel = sel; e.name = name;
    q5.push_back(e);
    @(negedge clk);
    bus5.sched_en = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20 && (q4.size() != 0 || q5.size() != 0); k++) @(negedge clk);
    if (q4.size() != 0 || q5.size() != 0) begin
      n_total++;
      $display("FAIL %s timeout: done pulse missing, %0d rounds outstanding", name,
               q4.size() + q5.size());
      q4.delete();
      q5.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic round4(input string name, input logic [3:0] busy, input logic [7:0] bvoq,
                        input logic [15:0] empty, input logic [3:0] en, input logic [14:0] sel);
    issue4(name, busy, bvoq, empty, 1'b1, en, sel);
    drain(name);
  endtask

  task automatic round5(input string name, input logic [24:0] empty,
                        input logic [4:0] en, input logic [14:0] sel);
    issue5(name, empty, en, sel);
    drain(name);
  endtask

  initial begin
    bus4.sched_en = 1'b0; bus4.is_busy = '0; bus4.busy_voq_num = '0; bus4.voq_empty = '1;
    bus5.sched_en = 1'b0; bus5.is_busy = '0; bus5.busy_voq_num = '0; bus5.voq_empty = '1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset active", int'(bus4.sched_active), 0);
    check("reset done", int'(bus4.sched_done), 0);
    check("reset sel_en", int'(bus4.sched_sel_en), 0);
    check("reset sel", int'(bus4.sched_sel), 0);
    check("reset dut5 active", int'(bus5.sched_active), 0);

    // all empty: nothing granted, start pointer moves to 1
    round4("t1 empty", 4'b0, 8'h0, 16'hFFFF, 4'b0000, s4(0, 0, 0, 0));
    round4("t1 start1", 4'b0, 8'h0, 16'h0000, 4'b1111, s4(3, 0, 1, 2));

    do_reset();
    round4("t2 r1", 4'b0, 8'h0, 16'h0000, 4'b1111, s4(0, 1, 2, 3));
`ifdef SCHED_EGRESS_RR_EN
    round4("t2 r2", 4'b0, 8'h0, 16'h0000, 4'b1111, s4(1, 2, 3, 0));
`else
    round4("t2 r2", 4'b0, 8'h0, 16'h0000, 4'b1111, s4(0, 1, 2, 3));
`endif

    do_reset();
    round4("t3 busy", 4'b0100, 8'(s4(0, 0, 1, 0)), 16'hFFFD, 4'b0100, s4(0, 0, 1, 0));

    // snapshot: live inputs and a stray request mid-round must not matter
    issue4("t4 snap", 4'b0, 8'h0, 16'h0000, 1'b1, 4'b1111, s4(3, 0, 1, 2));
    bus4.voq_empty    = '1;
    bus4.is_busy      = '1;
    bus4.busy_voq_num = '0;
    check("t4 active mid", int'(bus4.sched_active), 1);
    @(negedge clk);
    bus4.sched_en = 1'b1;
    @(negedge clk);
    bus4.sched_en = 1'b0;
    drain("t4 snap");
    repeat (8) @(negedge clk);
    check("t4 idle after", int'(bus4.sched_active), 0);
    bus4.is_busy = '0;

    // abort mid-ASSIGN
    issue4("t5 abort", 4'b0, 8'h0, 16'h0000, 1'b0, 4'b0, s4(0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5 active", int'(bus4.sched_active), 0);
    check("t5 done", int'(bus4.sched_done), 0);
    check("t5 sel_en", int'(bus4.sched_sel_en), 0);
    check("t5 sel", int'(bus4.sched_sel), 0);
    repeat (8) @(negedge clk);
    round4("t5 restart", 4'b0, 8'h0, 16'h0000, 4'b1111, s4(0, 1, 2, 3));

    round5("t6 voq3", {20'hFFFFF, 5'b10111}, 5'b00001, s5(3, 0, 0, 0, 0));
`ifdef SCHED_EGRESS_RR_EN
    round5("t6 ptr", {20'hFFFFF, 5'b01101}, 5'b00001, s5(4, 0, 0, 0, 0));
`else
    round5("t6 ptr", {20'hFFFFF, 5'b01101}, 5'b00001, s5(1, 0, 0, 0, 0));
`endif
    do_reset();
    round5("t6 r1", 25'h0, 5'b11111, s5(0, 1, 2, 3, 4));
`ifdef SCHED_EGRESS_RR_EN
    round5("t6 r2", 25'h0, 5'b11111, s5(1, 2, 3, 4, 0));
`else
    round5("t6 r2", 25'h0, 5'b11111, s5(0, 1, 2, 3, 4));
`endif

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
